seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
- Time-multiplexing scanner directly upstream of the registered hex-to-7-segment decoder.
- Holds a multi-digit hex value and presents one 4-bit nibble per scan slot to the decoder.
- Drives the matching digit-select (anode) lines, delayed one cycle to align with the decoder's registered segment output.
- New values load through a shadow register and take effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..8)
SCAN_DIV, 100000, clk_i cycles per digit slot (>=2)
AN_ACTIVE_LOW, 1, 1 = an_o active-low, 0 = active-high

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset
load_i  input  1  one-cycle strobe; capture value_i into shadow register
value_i  input  4*NUM_DIGITS  hex value; digit k = value_i[4k+3:4k], digit 0 = least significant
blank_i  input  NUM_DIGITS  per-digit blank mask, sampled live
nibble_o  output  4  nibble for current slot; feeds decoder input_data
an_o  output  NUM_DIGITS  digit select; one-hot active, aligned to decoder output
digit_idx_o  output  clog2(NUM_DIGITS)  index of digit currently on nibble_o
frame_o  output  1  one-cycle pulse on the last cycle of a full scan frame

Behaviour:
- Reset: rst_i (asynchronous, active-high) on clk_i.
  - prescaler=0, digit_idx_o=0, shadow=0, active=0, nibble_o=0, frame_o=0.
  - an_o all inactive (all 1s if AN_ACTIVE_LOW, else all 0s).
- Prescaler: counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1).
- Digit index: advances on tick; wraps NUM_DIGITS-1 -> 0.
- frame: frame = tick && digit_idx_o==NUM_DIGITS-1. frame_o is combinational from registered state.
- nibble_o: registered. nibble_o <= active[4*idx_next +: 4], where idx_next is the index after this edge. This makes nibble_o change on the same edge as digit_idx_o.
- an_o: registered, one cycle behind nibble_o, matching the decoder's 1-cycle latency.
  - Selects the previous cycle's digit_idx_o.
  - Inactive if that digit's blank bit (sampled with it) is set.
  - First clock after reset release: an_o selects digit 0.
- Load:
  - load_i=1 -> shadow <= value_i, pending flag set.
  - On frame with pending set: active <= shadow, pending cleared. The new value is visible starting at digit 0 of the next frame.
  - load_i coincident with frame: active <= value_i directly (bypass), pending cleared.
  - Back-to-back loads within one frame: the last one wins.
- Reset mid-frame: all state returns to reset values immediately; any pending load is discarded.
- SCAN_DIV and NUM_DIGITS are elaboration constants. Out-of-range values are a fatal elaboration error via static check.

Optional Feature:
- Macro SEG_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digits above the most significant nonzero digit of active are blanked (an_o inactive in their slot). Digit 0 is never suppressed. Combined with blank_i by OR. The suppression mask is registered and updated when active updates.
- Undefined: all digits are shown unless blank_i is set; no extra logic.

Decomposition:
- Package seg_pkg:
  - nibble_t (4-bit).
  - MAX_DIGITS=8.
  - AN_ON/AN_OFF helper constants keyed by polarity.
  - SEG_BLANK=8'h00 constant, shared with the decoder.
- Sub-module seg_scan_prescaler: parameter DIV; outputs tick; async reset. Reused by future blink/refresh logic.

Test Plan (sim params NUM_DIGITS=4, SCAN_DIV=4):
- Reset then release with value=0:
  - an_o=4'b1111 during reset.
  - One cycle after release, an_o=4'b1110; nibble_o=0.
  - frame_o pulses every 16 cycles.
- load_i with value_i=16'h1A2F mid-frame:
  - Display unchanged until frame_o.
  - Next frame nibble_o sequence F,2,A,1, each held 4 cycles.
  - an_o trails nibble_o by exactly 1 cycle.
- load_i exactly on the frame_o cycle with 16'h00C3: the next frame shows 3,C,0,0 with no one-frame delay.
- blank_i=4'b0100 with value 16'h1234: an_o stays 4'b1111 during the slot for digit 2; the other slots are normal.
- Assert rst_i mid-frame with a pending load: outputs reset asynchronously; after release, active=0 and the pending value is lost.
- With SEG_SCAN_LZ_BLANK_EN, value 16'h0050: digits 3 and 2 are blanked; digits 1 and 0 are shown. Value 16'h0000: only digit 0 is shown.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path (scanner and decoder).
package seg_pkg;

  typedef logic [3:0] nibble_t;

  localparam int MAX_DIGITS = 8;

  // Segment pattern that lights nothing; the decoder emits it for blanked slots.
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Anode levels keyed by polarity (1 = active-low board wiring).
  function automatic logic an_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic an_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// Free-running divide-by-DIV counter; tick is high on the last count of each period.
module seg_scan_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  generate
    if (DIV < 2) begin : g_bad_div
      $fatal(1, "seg_scan_prescaler: DIV must be >= 2");
    end
  endgenerate

  assign tick = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Digit scanner feeding the registered hex-to-7-segment decoder; anodes lag nibbles by one cycle.
// Optional leading-zero suppression when SEG_SCAN_LZ_BLANK_EN is defined.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV      = 100000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic [4*NUM_DIGITS-1:0]       value_i,
  input  logic [NUM_DIGITS-1:0]         blank_i,
  output logic [3:0]                    nibble_o,
  output logic [NUM_DIGITS-1:0]         an_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          frame_o
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic AN_ON_LVL  = an_on(AN_ACTIVE_LOW != 0);
  localparam logic AN_OFF_LVL = an_off(AN_ACTIVE_LOW != 0);

  generate
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $fatal(1, "seg_scan_mux: NUM_DIGITS must be 2..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
      $fatal(1, "seg_scan_mux: SCAN_DIV must be >= 2");
    end
  endgenerate

  logic                    tick;
  logic                    frame;
  logic [IDX_W-1:0]        idx_reg;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic                    pending_reg;
  logic [4*NUM_DIGITS-1:0] active_reg;
  logic [4*NUM_DIGITS-1:0] active_next;
  logic                    active_upd;
  nibble_t                 nibble_reg;
  nibble_t                 nibble_next;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [NUM_DIGITS-1:0]   hide_mask;

  seg_scan_prescaler #(
    .DIV (SCAN_DIV)
  ) u_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick  (tick)
  );

  assign frame = tick && (idx_reg == LAST_IDX);

  always_comb begin
    idx_next = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
  end

  // A load on the frame cycle bypasses the shadow so it is not a frame late.
  always_comb begin
    active_next = active_reg;
    active_upd  = 1'b0;
    if (frame && load_i) begin
      active_next = value_i;
      active_upd  = 1'b1;
    end else if (frame && pending_reg) begin
      active_next = shadow_reg;
      active_upd  = 1'b1;
    end
  end

  assign nibble_next = active_next[4*idx_next +: 4];

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_reg;
  logic [NUM_DIGITS-1:0] lz_next;

  // Digit k is a leading zero when every digit from k upward is zero; digit 0 always shows.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_next[gi] = 1'b0;
      end else begin : g_upper
        assign lz_next[gi] = ~|active_next[4*NUM_DIGITS-1:4*gi];
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lz_reg <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else if (active_upd) begin
      lz_reg <= lz_next;
    end
  end

  assign hide_mask = blank_i | lz_reg;
`else
  assign hide_mask = blank_i;
`endif

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_next[gi] = (idx_reg == IDX_W'(gi) && !hide_mask[gi]) ? AN_ON_LVL : AN_OFF_LVL;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_reg     <= '0;
      shadow_reg  <= '0;
      pending_reg <= 1'b0;
      active_reg  <= '0;
      nibble_reg  <= '0;
      an_reg      <= {NUM_DIGITS{AN_OFF_LVL}};
    end else begin
      idx_reg    <= idx_next;
      active_reg <= active_next;
      nibble_reg <= nibble_next;
      an_reg     <= an_next;
      if (load_i) begin
        shadow_reg <= value_i;
      end
      if (frame) begin
        pending_reg <= 1'b0;
      end else if (load_i) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign nibble_o    = nibble_reg;
  assign an_o        = an_reg;
  assign digit_idx_o = idx_reg;
  assign frame_o     = frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (4 digits, 4 cycles per slot); covers SEG_SCAN_LZ_BLANK_EN too.
module tb_seg_scan_mux;

  localparam int ND  = 4;
  localparam int DIV = 4;
  localparam int FRAME_LEN = ND * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [1:0]  idx;
  logic        frame;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic [1:0] idx;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  // Reference: state is a function of m_c, the number of edges since reset release.
  int          m_c;
  logic [15:0] m_act;
  logic [15:0] m_shadow;
  logic        m_pend;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (DIV),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .value_i     (value),
    .blank_i     (blank),
    .nibble_o    (nibble),
    .an_o        (an),
    .digit_idx_o (idx),
    .frame_o     (frame)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, got, want);
    end
  endtask

  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m = 4'b0000;
`ifdef SEG_SCAN_LZ_BLANK_EN
    for (int k = 1; k < ND; k++) begin
      if ((v >> (4 * k)) == 16'h0) m[k] = 1'b1;
    end
`endif
    return m;
  endfunction

  // Predict the outputs after the coming edge, push them, then compare on the next negedge.
  task automatic step();
    exp_t        e;
    exp_t        got;
    logic [15:0] act_old;
    logic [3:0]  hide;
    int          cn;
    int          k;
    act_old = m_act;
    cn = m_c + 1;
    if (load && (m_c % FRAME_LEN == FRAME_LEN - 1)) begin
      m_act  = value;
      m_pend = 1'b0;
    end else begin
      if ((m_c % FRAME_LEN == FRAME_LEN - 1) && m_pend) begin
        m_act  = m_shadow;
        m_pend = 1'b0;
      end
      if (load) begin
        m_shadow = value;
        m_pend   = 1'b1;
      end
    end
    e.nib   = 4'((m_act >> (4 * ((cn / DIV) % ND))) & 16'hF);
    e.idx   = 2'((cn / DIV) % ND);
    e.frame = (cn % FRAME_LEN == FRAME_LEN - 1);
    k = (m_c / DIV) % ND;
    hide = blank | lz_mask(act_old);
    e.an = hide[k] ? 4'b1111 : ~(4'b0001 << k);
    sb.push_back(e);
    @(posedge clk);
    m_c = cn;
    @(negedge clk);
    got = sb.pop_front();
    chk("nibble", {28'h0, nibble}, {28'h0, got.nib});
    chk("an", {28'h0, an}, {28'h0, got.an});
    chk("digit_idx", {30'h0, idx}, {30'h0, got.idx});
    chk("frame", {31'h0, frame}, {31'h0, got.frame});
    $display("cyc %0d idx=%0d nibble=%h an=%b frame=%0b", m_c, idx, nibble, an, frame);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go_phase(input int ph);
    for (int i = 0; i < FRAME_LEN && (m_c % FRAME_LEN) != ph; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic model_reset();
    m_c      = 0;
    m_act    = 16'h0;
    m_shadow = 16'h0;
    m_pend   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"}, {28'h0, an}, 32'hF);
    chk({tag, "_nibble"}, {28'h0, nibble}, 32'h0);
    chk({tag, "_idx"}, {30'h0, idx}, 32'h0);
    chk({tag, "_frame"}, {31'h0, frame}, 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    blank = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Idle scan of zero: anode walks, frame every 16 cycles.
    run(2 * FRAME_LEN);

    // Two loads in one frame: the later one is shown from the next frame.
    go_phase(3);
    do_load(16'h5555);
    run(1);
    do_load(16'h1A2F);
    run(3 * FRAME_LEN);

    // Load exactly on the frame cycle takes effect immediately.
    go_phase(FRAME_LEN - 1);
    do_load(16'h00C3);
    run(2 * FRAME_LEN);

    // Live blank mask on digit 2.
    go_phase(4);
    do_load(16'h1234);
    go_phase(0);
    blank = 4'b0100;
    run(2 * FRAME_LEN);
    blank = 4'b0000;
    run(FRAME_LEN);

    // Asynchronous reset mid-frame drops a pending load.
    go_phase(6);
    do_load(16'hBEEF);
    run(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    check_reset_outputs("held_rst");
    rst = 1'b0;
    run(2 * FRAME_LEN);

    // Leading-zero cases (plain display when suppression is not built in).
    go_phase(2);
    do_load(16'h0050);
    run(2 * FRAME_LEN);
    go_phase(2);
    do_load(16'h0000);
    run(2 * FRAME_LEN);
    go_phase(FRAME_LEN - 1);
    do_load(16'h7000);
    run(FRAME_LEN + 2);

    // Random loads and blank masks.
    for (int i = 0; i < 160; i++) begin
      blank = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 9) == 0) begin
        do_load(16'($urandom()));
      end else begin
        step();
      end
    end

    chk("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
